// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: size codes, FSM states and
// the alignment check used when a request is accepted.
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  localparam int DEFAULT_MEM_WORDS = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Halves must sit on even bytes and words on 4-byte boundaries.
  // Bytes are always aligned; the illegal size code is checked separately.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_merge.sv
// Combinational byte-lane logic: extracts and extends a load from the
// addressed lanes, and merges right-aligned store data into a memory word.
module lsu_lane_merge
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [31:0] shifted;
  logic [31:0] wdata_rep;
  logic [3:0]  lane_sel;

  // Bring the addressed byte down to bit 0 (little-endian lanes).
  assign shifted = word >> {addr_lo, 3'b000};

  // Sign- or zero-extend the extracted lane; word loads pass through.
  always_comb begin
    load_data = shifted;
    case (size)
      SZ_BYTE: load_data = {{24{~uns & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = {{16{~uns & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // Replicate store data across lanes so each lane can pick its slice directly.
  always_comb begin
    wdata_rep = wdata;
    case (size)
      SZ_BYTE: wdata_rep = {4{wdata[7:0]}};
      SZ_HALF: wdata_rep = {2{wdata[15:0]}};
      default: wdata_rep = wdata;
    endcase
  end

  // Each lane takes new data only if the access covers it.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE = 2'(gi);
      assign lane_sel[gi] = (size == SZ_BYTE) ? (addr_lo == LANE) :
                            (size == SZ_HALF) ? (addr_lo[1] == LANE[1]) :
                            1'b1;
      assign store_word[8*gi +: 8] = lane_sel[gi] ? wdata_rep[8*gi +: 8] : word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-addressed data memory. One request is
// handled at a time: validate, optionally read, optionally write, respond.
// Sub-word stores are done as read-modify-write of the containing word.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = DEFAULT_MEM_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic        mem_we,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  localparam logic [29:0] MEM_LIMIT = 30'(MEM_WORDS);

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] rdata_reg;
  logic [31:0] mem_wd_reg;
  logic [1:0]  size_reg;
  logic        we_reg;
  logic        uns_reg;
  logic        err_reg;

  logic        accept;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] store_word;

  assign accept  = req_valid && (state_reg == IDLE);
  assign req_err = (req_size == SZ_ILL) ||
                   misaligned(req_size, req_addr[1:0]) ||
                   (req_addr[31:2] >= MEM_LIMIT);

  // Memory side is driven purely from latched request state.
  assign mem_a      = {addr_reg[31:2], 2'b00};
  assign mem_wd     = mem_wd_reg;
  assign resp_rdata = rdata_reg;
  assign resp_err   = err_reg;

  lsu_lane_merge u_lane_merge (
    .word       (mem_rd),
    .addr_lo    (addr_reg[1:0]),
    .size       (size_reg),
    .uns        (uns_reg),
    .wdata      (wdata_reg),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // FSM state register; reset aborts any request in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic and handshake/write-enable decode.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err) begin
            state_next = RESP;
          end else if (req_we && (req_size == SZ_WORD)) begin
            state_next = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        state_next = we_reg ? WRITE : RESP;
      end
      WRITE: begin
        mem_we     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Request latch, load result and write-data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg   <= '0;
      wdata_reg  <= '0;
      rdata_reg  <= '0;
      mem_wd_reg <= '0;
      size_reg   <= SZ_BYTE;
      we_reg     <= 1'b0;
      uns_reg    <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      if (accept) begin
        addr_reg  <= req_addr;
        wdata_reg <= req_wdata;
        size_reg  <= req_size;
        we_reg    <= req_we;
        uns_reg   <= req_unsigned;
        err_reg   <= req_err;
        rdata_reg <= '0;
        // Word stores skip the read, so their data is final right away.
        if (req_we) begin
          mem_wd_reg <= req_wdata;
        end
      end else if (state_reg == READ) begin
        if (we_reg) begin
          mem_wd_reg <= store_word;
        end else begin
          rdata_reg <= load_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw: a word memory attached to the mem_* port, a
// byte-level reference model of memory and responses, and a per-cycle
// compare process on the response and write ports.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_a, mem_wd, mem_rd;
  logic        mem_we;

  int tests = 0;
  int fails = 0;

  lsu_rmw #(.MEM_WORDS(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 4) ? 32'h8899AABB : (32'h01010101 * i) ^ 32'hA5A5A5A5;
  endfunction

  // Attached data memory: combinational read, write at the clock edge.
  logic [31:0] mem [0:63];
  logic        mem_init = 1'b0;
  assign mem_rd = mem[mem_a[7:2]];
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_we) begin
      mem[mem_a[7:2]] <= mem_wd;
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rdata, exp_wa, exp_wd;
  logic        exp_err, exp_wr;
  logic [5:0]  exp_idx;
  int          exp_lat;
  int          we_count;
  logic        cur_we;
  logic [1:0]  cur_size;
  logic [31:0] cur_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Expected outcome from the access rules, computed byte by byte.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int nb, lane;
    logic [31:0] w, v;
    exp_err   = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
                (size == 2'b10 && addr[1:0] != 2'b00) || (addr[31:2] >= 30'd64);
    exp_rdata = 32'h0;
    exp_wr    = 1'b0;
    exp_wd    = 32'h0;
    exp_idx   = addr[7:2];
    exp_wa    = {addr[31:2], 2'b00};
    if (exp_err) begin
      exp_lat = 1;
    end else begin
      nb   = 1 << size;
      lane = int'(addr[1:0]);
      w    = ref_mem[exp_idx];
      if (!we) begin
        v = 32'h0;
        for (int i = 0; i < nb; i++)
          v = v | (((w >> (8 * (lane + i))) & 32'hFF) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1])
          v = v | ~((32'h1 << (8 * nb)) - 32'h1);
        exp_rdata = v;
        exp_lat   = 2;
      end else begin
        for (int i = 0; i < nb; i++) begin
          w = w & ~(32'hFF << (8 * (lane + i)));
          w = w | (((wdata >> (8 * i)) & 32'hFF) << (8 * (lane + i)));
        end
        exp_wr  = 1'b1;
        exp_wd  = w;
        exp_lat = (nb == 4) ? 2 : 3;
      end
    end
  endtask

  // Per-cycle compare of response and write ports against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid) begin
        check("resp_rdata", resp_rdata, exp_rdata);
        check("resp_err", 32'(resp_err), 32'(exp_err));
      end
      if (mem_we) begin
        we_count++;
        check("mem_a", mem_a, exp_wa);
        check("mem_wd", mem_wd, exp_wd);
      end
    end
  end

  // Present a request and let it be accepted; req_valid stays high.
  task automatic start_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    model(we, size, uns, addr, wdata);
    cur_we = we; cur_size = size; cur_addr = addr;
    we_count = 0;
    req_we = we; req_size = size; req_unsigned = uns; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
  endtask

  // Wait for the response and check latency, write timing and literal values.
  task automatic wait_resp(input logic [31:0] lit_rdata, input logic lit_err);
    int cyc, we_cyc;
    cyc = 1;
    we_cyc = -1;
    while (!resp_valid && cyc < 20) begin
      if (mem_we) we_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
    end
    if (!resp_valid) begin
      tests++;
      fails++;
      $display("FAIL resp_timeout: got no response after %0d cycles, expected one at %0d", cyc, exp_lat);
    end else begin
      check("latency", 32'(cyc), 32'(exp_lat));
      check("rdata_lit", resp_rdata, lit_rdata);
      check("err_lit", 32'(resp_err), 32'(lit_err));
      if (exp_wr) check("we_cycle", 32'(we_cyc), 32'(exp_lat - 1));
    end
    $display("[TB] txn we=%0d size=%0d addr=%h lat=%0d rdata=%h err=%0d",
             cur_we, cur_size, cur_addr, cyc, resp_rdata, resp_err);
  endtask

  // Take the response, then retire the model and compare the memory word.
  task automatic handshake();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("resp_valid_drop", 32'(resp_valid), 32'd0);
    check("we_count", 32'(we_count), exp_wr ? 32'd1 : 32'd0);
    if (exp_wr) ref_mem[exp_idx] = exp_wd;
    check("mem_word", mem[exp_idx], ref_mem[exp_idx]);
  endtask

  task automatic run_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] lit_rdata, input logic lit_err);
    start_req(we, size, uns, addr, wdata);
    req_valid = 1'b0;
    wait_resp(lit_rdata, lit_err);
    handshake();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_mem_a"}, mem_a, 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_wd"}, mem_wd, 32'd0);
  endtask

  initial begin
    int seen_resp;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    exp_rdata = 32'h0; exp_err = 1'b0; exp_wr = 1'b0; exp_wa = 32'h0; exp_wd = 32'h0;
    exp_idx = 6'd0; exp_lat = 0; we_count = 0;
    cur_we = 1'b0; cur_size = 2'b00; cur_addr = 32'h0;
    #1;
    check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Loads from the preloaded word 0x8899AABB at 0x10.
    run_req(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0);
    run_req(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000088, 1'b0);
    run_req(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFF8899, 1'b0);
    run_req(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h0000AABB, 1'b0);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0);

    // Sub-word store merges into the word.
    run_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h000000CC, 32'h0, 1'b0);
    check("mem10_after_sb", mem[4], 32'h8899CCBB);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899CCBB, 1'b0);

    // Misaligned / illegal size / out of range never write.
    run_req(1'b1, 2'b01, 1'b0, 32'h13, 32'h00001234, 32'h0, 1'b1);
    run_req(1'b1, 2'b11, 1'b0, 32'h10, 32'h00001234, 32'h0, 1'b1);
    check("mem10_after_err", mem[4], 32'h8899CCBB);
    run_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h12345678, 32'h0, 1'b1);
    run_req(1'b0, 2'b10, 1'b0, 32'h16, 32'h0, 32'h0, 1'b1);

    // Word store at the last word, then read it back.
    run_req(1'b1, 2'b10, 1'b0, 32'hFC, 32'hDEADBEEF, 32'h0, 1'b0);
    check("mem_fc", mem[63], 32'hDEADBEEF);
    run_req(1'b0, 2'b00, 1'b0, 32'hFF, 32'h0, 32'hFFFFFFDE, 1'b0);
    run_req(1'b1, 2'b01, 1'b0, 32'h22, 32'h1234ABCD, 32'h0, 1'b0);
    run_req(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'h0000ABCD, 1'b0);

    // Back-pressure: response held, next request waits for the handshake.
    start_req(1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    req_size = 2'b01; req_unsigned = 1'b1; req_addr = 32'h12;
    wait_resp(32'h000000BB, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_resp_valid", 32'(resp_valid), 32'd1);
      check("stall_req_ready", 32'(req_ready), 32'd0);
      check("stall_rdata", resp_rdata, 32'h000000BB);
    end
    handshake();
    check("req_ready_after_hs", 32'(req_ready), 32'd1);
    start_req(1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
    req_valid = 1'b0;
    wait_resp(32'h00008899, 1'b0);
    handshake();

    // Reset during the read phase of a byte store.
    start_req(1'b1, 2'b00, 1'b0, 32'h12, 32'h00000055);
    req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_resp = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (resp_valid) seen_resp++;
    end
    check("midrst_no_resp", 32'(seen_resp), 32'd0);
    check("midrst_we_count", 32'(we_count), 32'd0);
    check("midrst_mem", mem[4], 32'h8899CCBB);
    run_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899CCBB, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000 time units");
    $fatal(1);
  end

endmodule
